// File: rtl/execute_bru_pipe_pkg.sv
// Shared execute-stage types for the branch resolve unit: op codes, issue/writeback/feedback packs, checkpoint.
// Used by execute_bru_pipe and its writeback queue.
package execute_bru_pipe_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int REG_DATA_WIDTH      = 32;
    localparam int INSTR_WIDTH         = 32;
    localparam int CHECKPOINT_ID_WIDTH = 4;
    localparam int PHY_REG_ID_WIDTH    = 6;
    localparam int ROB_ID_WIDTH        = 5;
    localparam int EXC_ID_WIDTH        = 5;

    typedef enum logic [3:0] {
        BRU_BEQ  = 4'd0,
        BRU_BNE  = 4'd1,
        BRU_BLT  = 4'd2,
        BRU_BGE  = 4'd3,
        BRU_BLTU = 4'd4,
        BRU_BGEU = 4'd5,
        BRU_JAL  = 4'd6,
        BRU_JALR = 4'd7,
        BRU_MRET = 4'd8
    } bru_op_t;

    typedef struct packed {
        logic [15:0] global_history;
        logic [3:0]  ras_ptr;
    } checkpoint_t;

    typedef struct packed {
        logic                           enable;
        logic                           valid;
        logic [ROB_ID_WIDTH-1:0]        rob_id;
        logic [ADDR_WIDTH-1:0]          pc;
        logic [INSTR_WIDTH-1:0]         inst_value;
        logic                           rd_enable;
        logic                           need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
        logic [REG_DATA_WIDTH-1:0]      src1_value;
        logic [REG_DATA_WIDTH-1:0]      src2_value;
        logic [ADDR_WIDTH-1:0]          imm;
        bru_op_t                        op;
        logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
        logic                           predicted_jump;
        logic [ADDR_WIDTH-1:0]          predicted_next_pc;
        logic                           has_exception;
        logic [EXC_ID_WIDTH-1:0]        exception_id;
        logic [REG_DATA_WIDTH-1:0]      exception_value;
    } issue_execute_pack_t;

    typedef struct packed {
        logic                        enable;
        logic                        valid;
        logic [ROB_ID_WIDTH-1:0]     rob_id;
        logic [ADDR_WIDTH-1:0]       pc;
        logic [INSTR_WIDTH-1:0]      inst_value;
        logic                        rd_enable;
        logic                        need_rename;
        logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
        logic [REG_DATA_WIDTH-1:0]   rd_value;
        logic                        bru_jump;
        logic [ADDR_WIDTH-1:0]       bru_next_pc;
        logic                        has_exception;
        logic [EXC_ID_WIDTH-1:0]     exception_id;
        logic [REG_DATA_WIDTH-1:0]   exception_value;
    } execute_wb_pack_t;

    typedef struct packed {
        logic                        enable;
        logic [PHY_REG_ID_WIDTH-1:0] phy_id;
        logic [REG_DATA_WIDTH-1:0]   value;
    } execute_feedback_channel_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

endpackage

// File: rtl/execute_bru_pipe_queue.sv
// Power-of-two circular FIFO between the resolve register and the writeback port.
// Handshake: push/pop are single-cycle strobes; the caller never pushes when full or pops when empty.
module execute_bru_pipe_queue #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Pointers are exactly PW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/execute_bru_pipe.sv
// Branch resolve unit: E1 resolve register feeding a writeback queue, with predictor update and early wakeup.
// Optional BRU_MISPRED_CNT_EN adds the mispred_count output.
module execute_bru_pipe
    import execute_bru_pipe_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  issue_execute_pack_t            issue_bru_fifo_data_out,
    input  logic                           issue_bru_fifo_data_out_valid,
    output logic                           issue_bru_fifo_pop,
    input  logic [REG_DATA_WIDTH-1:0]      csrf_all_mepc_data,
    output logic [CHECKPOINT_ID_WIDTH-1:0] exbru_cpbuf_id,
    input  checkpoint_t                    cpbuf_exbru_data,
    output execute_wb_pack_t               bru_wb_port_data_in,
    output logic                           bru_wb_port_we,
    input  logic                           bru_wb_port_ready,
    output logic                           bru_wb_port_flush,
    output execute_feedback_channel_t      bru_execute_channel_feedback_pack,
    input  commit_feedback_pack_t          commit_feedback_pack,
    output logic                           exbru_bp_valid,
    output logic [ADDR_WIDTH-1:0]          exbru_bp_pc,
    output logic [INSTR_WIDTH-1:0]         exbru_bp_instruction,
    output logic                           exbru_bp_jump,
    output logic [ADDR_WIDTH-1:0]          exbru_bp_next_pc,
    output logic                           exbru_bp_hit,
    output checkpoint_t                    exbru_bp_cp
`ifdef BRU_MISPRED_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]           mispred_count
`endif
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    issue_execute_pack_t   head;
    execute_wb_pack_t      res;
    execute_wb_pack_t      e1_entry;
    execute_wb_pack_t      q_head;
    checkpoint_t           e1_cp;
    logic [ADDR_WIDTH-1:0] pc_plus4, br_target, target;
    logic                  taken, is_link, active, res_hit;
    logic                  flush_now, pop_int, push, q_pop, we_int, bp_valid_int;
    logic                  e1_valid, e1_active, e1_hit;
    logic [CW-1:0]         q_count;
    logic [CW:0]           occupancy;

    assign flush_now = commit_feedback_pack.enable && commit_feedback_pack.flush;
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, e1_valid};
    assign pop_int   = rst && issue_bru_fifo_data_out_valid && !flush_now
                       && (occupancy < (CW+1)'(QUEUE_DEPTH));

    always_comb begin
        head      = issue_bru_fifo_data_out;
        pc_plus4  = head.pc + ADDR_WIDTH'(4);
        br_target = head.pc + head.imm;
        taken     = 1'b0;
        is_link   = 1'b0;
        target    = pc_plus4;
        case (head.op)
            BRU_BEQ:  begin taken = (head.src1_value == head.src2_value);                   target = br_target; end
            BRU_BNE:  begin taken = (head.src1_value != head.src2_value);                   target = br_target; end
            BRU_BLT:  begin taken = ($signed(head.src1_value) <  $signed(head.src2_value));  target = br_target; end
            BRU_BGE:  begin taken = ($signed(head.src1_value) >= $signed(head.src2_value));  target = br_target; end
            BRU_BLTU: begin taken = (head.src1_value <  head.src2_value);                   target = br_target; end
            BRU_BGEU: begin taken = (head.src1_value >= head.src2_value);                   target = br_target; end
            BRU_JAL:  begin taken = 1'b1; is_link = 1'b1; target = br_target; end
            BRU_JALR: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = (head.src1_value + head.imm) & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
            end
            BRU_MRET: begin taken = 1'b1; target = csrf_all_mepc_data; end
            default:  ;
        endcase

        // Bubbles and excepting entries flow through unresolved so the ROB still sees them.
        active              = head.enable && head.valid && !head.has_exception;
        res                 = '0;
        res.enable          = head.enable;
        res.valid           = head.valid;
        res.rob_id          = head.rob_id;
        res.pc              = head.pc;
        res.inst_value      = head.inst_value;
        res.rd_enable       = head.rd_enable;
        res.need_rename     = head.need_rename;
        res.rd_phy          = head.rd_phy;
        res.has_exception   = head.has_exception;
        res.exception_id    = head.exception_id;
        res.exception_value = head.exception_value;
        res.bru_jump        = active && taken;
        res.bru_next_pc     = (active && taken) ? target : pc_plus4;
        res.rd_value        = (active && is_link) ? pc_plus4 : '0;
        res_hit             = (taken == head.predicted_jump)
                              && (!taken || (head.predicted_next_pc == target));
    end

    // E1 always drains into the queue the next cycle; pop already reserved the slot.
    always_ff @(posedge clk) begin
        if (!rst || flush_now) begin
            e1_valid  <= 1'b0;
            e1_active <= 1'b0;
        end else begin
            e1_valid  <= pop_int;
            e1_active <= pop_int && active;
        end
    end

    always_ff @(posedge clk) begin
        if (pop_int) begin
            e1_entry <= res;
            e1_hit   <= res_hit;
            e1_cp    <= cpbuf_exbru_data;
        end
    end

    assign push   = e1_valid && !flush_now;
    assign we_int = rst && !flush_now && (q_count != '0);
    assign q_pop  = we_int && bru_wb_port_ready;

    execute_bru_pipe_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (execute_wb_pack_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_now),
        .push      (push),
        .push_data (e1_entry),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    assign bp_valid_int = rst && !flush_now && e1_valid && e1_active;

    always_comb begin
        issue_bru_fifo_pop                       = pop_int;
        exbru_cpbuf_id                           = rst ? head.checkpoint_id : '0;
        bru_wb_port_we                           = we_int;
        bru_wb_port_data_in                      = rst ? q_head : '0;
        bru_wb_port_flush                        = !rst || flush_now;
        bru_execute_channel_feedback_pack        = '0;
        if (bp_valid_int && e1_entry.rd_enable && e1_entry.need_rename) begin
            bru_execute_channel_feedback_pack.enable = 1'b1;
            bru_execute_channel_feedback_pack.phy_id = e1_entry.rd_phy;
            bru_execute_channel_feedback_pack.value  = e1_entry.rd_value;
        end
        exbru_bp_valid       = bp_valid_int;
        exbru_bp_pc          = rst ? e1_entry.pc : '0;
        exbru_bp_instruction = rst ? e1_entry.inst_value : '0;
        exbru_bp_jump        = rst ? e1_entry.bru_jump : 1'b0;
        exbru_bp_next_pc     = rst ? e1_entry.bru_next_pc : '0;
        exbru_bp_hit         = rst ? e1_hit : 1'b0;
        exbru_bp_cp          = rst ? e1_cp : '0;
    end

`ifdef BRU_MISPRED_CNT_EN
    logic [CNT_WIDTH-1:0] mispred_cnt_q;

    // Survives pipeline flushes; only reset clears the statistic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mispred_cnt_q <= '0;
        end else if (bp_valid_int && !e1_hit) begin
            mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
    end

    assign mispred_count = rst ? mispred_cnt_q : '0;
`endif

endmodule

// File: tb/tb_execute_bru_pipe.sv
// Directed bench for execute_bru_pipe; checks mispred_count when BRU_MISPRED_CNT_EN is defined.
module tb_execute_bru_pipe;
    import execute_bru_pipe_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    issue_execute_pack_t            head;
    logic                           head_valid;
    logic                           pop;
    logic [REG_DATA_WIDTH-1:0]      mepc;
    logic [CHECKPOINT_ID_WIDTH-1:0] cpbuf_id;
    checkpoint_t                    cp_data;
    execute_wb_pack_t               wb_data;
    logic                           wb_we;
    logic                           wb_ready;
    logic                           wb_flush;
    execute_feedback_channel_t      fb;
    commit_feedback_pack_t          commit;
    logic                           bp_valid;
    logic [ADDR_WIDTH-1:0]          bp_pc;
    logic [INSTR_WIDTH-1:0]         bp_instr;
    logic                           bp_jump;
    logic [ADDR_WIDTH-1:0]          bp_next_pc;
    logic                           bp_hit;
    checkpoint_t                    bp_cp;
`ifdef BRU_MISPRED_CNT_EN
    logic [31:0]                    mispred_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [ROB_ID_WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    execute_bru_pipe #(.QUEUE_DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk                               (clk),
        .rst                               (rst),
        .issue_bru_fifo_data_out           (head),
        .issue_bru_fifo_data_out_valid     (head_valid),
        .issue_bru_fifo_pop                (pop),
        .csrf_all_mepc_data                (mepc),
        .exbru_cpbuf_id                    (cpbuf_id),
        .cpbuf_exbru_data                  (cp_data),
        .bru_wb_port_data_in               (wb_data),
        .bru_wb_port_we                    (wb_we),
        .bru_wb_port_ready                 (wb_ready),
        .bru_wb_port_flush                 (wb_flush),
        .bru_execute_channel_feedback_pack (fb),
        .commit_feedback_pack              (commit),
        .exbru_bp_valid                    (bp_valid),
        .exbru_bp_pc                       (bp_pc),
        .exbru_bp_instruction              (bp_instr),
        .exbru_bp_jump                     (bp_jump),
        .exbru_bp_next_pc                  (bp_next_pc),
        .exbru_bp_hit                      (bp_hit),
        .exbru_bp_cp                       (bp_cp)
`ifdef BRU_MISPRED_CNT_EN
        ,
        .mispred_count                     (mispred_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic issue_execute_pack_t mk(input bru_op_t op, input logic [31:0] pc, s1, s2, imm,
                                               input logic pj, input logic [31:0] pnpc,
                                               input logic [ROB_ID_WIDTH-1:0] rob);
        issue_execute_pack_t p;
        p                   = '0;
        p.enable            = 1'b1;
        p.valid             = 1'b1;
        p.op                = op;
        p.pc                = pc;
        p.src1_value        = s1;
        p.src2_value        = s2;
        p.imm               = imm;
        p.predicted_jump    = pj;
        p.predicted_next_pc = pnpc;
        p.rob_id            = rob;
        p.inst_value        = 32'h0000_0063 ^ {27'd0, rob};
        return p;
    endfunction

    // Presents one entry, waits (bounded) for pop, then lets the edge load E1.
    task automatic issue(input issue_execute_pack_t p);
        int n;
        head       = p;
        head_valid = 1'b1;
        #1;
        n = 0;
        while (!pop && n < 20) begin
            step();
            n++;
        end
        chk("issue_pop", pop, 1);
        chk("cpbuf_id", cpbuf_id, p.checkpoint_id);
        step();
        head_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        issue_execute_pack_t p;
        int npops;
        int n;
        logic [ROB_ID_WIDTH-1:0] next_id;
        logic [ROB_ID_WIDTH-1:0] exp_id;

        rst        = 1'b0;
        head       = mk(BRU_BEQ, 32'h100, 32'h1, 32'h1, 32'h8, 1'b0, 32'h0, 5'd0);
        head.checkpoint_id = 4'd9;
        head_valid = 1'b1;
        mepc       = 32'h8000_1000;
        cp_data    = '{global_history: 16'hABCD, ras_ptr: 4'h3};
        wb_ready   = 1'b1;
        commit     = '0;

        // Reset for two cycles with a valid head waiting.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_flush", wb_flush, 1);
            chk("rst_we", wb_we, 0);
            chk("rst_pop", pop, 0);
            chk("rst_bp_valid", bp_valid, 0);
            chk("rst_fb", fb.enable, 0);
            chk("rst_cpbuf_id", cpbuf_id, 0);
`ifdef BRU_MISPRED_CNT_EN
            chk("rst_mispred", mispred_count, 0);
`endif
        end
        rst        = 1'b1;
        head_valid = 1'b0;
        step();
        chk("idle_flush", wb_flush, 0);

        // beq taken, predicted not taken.
        p = mk(BRU_BEQ, 32'h1526c2d8, 32'h15286679, 32'h15286679, 32'h18745658, 1'b0, 32'h0, 5'd1);
        p.checkpoint_id = 4'd5;
        issue(p);
        chk("beq_bp_valid", bp_valid, 1);
        chk("beq_bp_jump", bp_jump, 1);
        chk("beq_bp_hit", bp_hit, 0);
        chk("beq_bp_next_pc", bp_next_pc, 32'h2d9b1930);
        chk("beq_bp_pc", bp_pc, 32'h1526c2d8);
        chk("beq_bp_cp", bp_cp, {16'hABCD, 4'h3});
        chk("beq_we_early", wb_we, 0);
        step();
        chk("beq_bp_once", bp_valid, 0);
        chk("beq_we", wb_we, 1);
        chk("beq_next_pc", wb_data.bru_next_pc, 32'h2d9b1930);
        chk("beq_jump", wb_data.bru_jump, 1);
        chk("beq_rd_value", wb_data.rd_value, 0);
        step();
        chk("beq_drained", wb_we, 0);

        // jal with rename: early wakeup one cycle after pop.
        p = mk(BRU_JAL, 32'h1526c2d8, 32'h0, 32'h0, 32'h100, 1'b0, 32'h0, 5'd2);
        p.rd_enable = 1'b1; p.need_rename = 1'b1; p.rd_phy = 6'd10;
        issue(p);
        chk("jal_fb_en", fb.enable, 1);
        chk("jal_fb_phy", fb.phy_id, 10);
        chk("jal_fb_value", fb.value, 32'h1526c2dc);
        step();
        chk("jal_fb_once", fb.enable, 0);
        chk("jal_next_pc", wb_data.bru_next_pc, 32'h1526c3d8);
        chk("jal_rd_value", wb_data.rd_value, 32'h1526c2dc);
        step();

        // Unsigned vs signed compare on the same operands.
        issue(mk(BRU_BLTU, 32'h1000, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 32'h0, 5'd3));
        chk("bltu_jump", bp_jump, 0);
        chk("bltu_hit", bp_hit, 1);
        chk("bltu_next_pc", bp_next_pc, 32'h1004);
        step();
        issue(mk(BRU_BLT, 32'h1000, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b1, 32'h1040, 5'd4));
        chk("blt_jump", bp_jump, 1);
        chk("blt_hit", bp_hit, 1);
        chk("blt_next_pc", bp_next_pc, 32'h1040);
        step();

        // jalr clears bit 0; predicted target wrong.
        issue(mk(BRU_JALR, 32'h2000, 32'h1001, 32'h0, 32'h10, 1'b1, 32'h1014, 5'd5));
        chk("jalr_next_pc", bp_next_pc, 32'h1010);
        chk("jalr_hit", bp_hit, 0);
        step();
        issue(mk(BRU_MRET, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h8000_1000, 5'd6));
        chk("mret_next_pc", bp_next_pc, 32'h8000_1000);
        chk("mret_hit", bp_hit, 1);
        step();

        // Excepting jal passes through with no wakeup or predictor update.
        p = mk(BRU_JAL, 32'h4000, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0, 5'd7);
        p.rd_enable = 1'b1; p.need_rename = 1'b1; p.rd_phy = 6'd12;
        p.has_exception = 1'b1; p.exception_id = 5'd3; p.exception_value = 32'hDEAD_0000;
        issue(p);
        chk("exc_fb", fb.enable, 0);
        chk("exc_bp_valid", bp_valid, 0);
        step();
        chk("exc_we", wb_we, 1);
        chk("exc_jump", wb_data.bru_jump, 0);
        chk("exc_flag", wb_data.has_exception, 1);
        chk("exc_id", wb_data.exception_id, 3);
        chk("exc_value", wb_data.exception_value, 32'hDEAD_0000);
        step();

        // Backpressure: exactly QUEUE_DEPTH pops, then in-order drain.
        wb_ready   = 1'b0;
        head       = mk(BRU_BNE, 32'h5000, 32'h1, 32'h2, 32'h8, 1'b1, 32'h5008, 5'd8);
        head_valid = 1'b1;
        next_id    = 5'd8;
        npops      = 0;
        for (int i = 0; i < 10; i++) begin
            head.rob_id = next_id;
            #1;
            if (pop) begin
                exp_q.push_back(next_id);
                next_id = next_id + 1'b1;
                npops++;
            end
            step();
        end
        chk("full_npops", npops, 4);
        #1;
        chk("full_pop_low", pop, 0);
        head_valid = 1'b0;
        wb_ready   = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            exp_id = exp_q.pop_front();
            chk("drain_we", wb_we, 1);
            chk("drain_order", wb_data.rob_id, exp_id);
            step();
            n++;
        end
        chk("drain_empty", wb_we, 0);

        // Flush with three entries queued.
        wb_ready = 1'b0;
        issue(mk(BRU_BEQ, 32'h6000, 32'h1, 32'h1, 32'h8, 1'b1, 32'h6008, 5'd20));
        issue(mk(BRU_BEQ, 32'h6004, 32'h1, 32'h1, 32'h8, 1'b1, 32'h600c, 5'd21));
        issue(mk(BRU_BEQ, 32'h6008, 32'h1, 32'h1, 32'h8, 1'b1, 32'h6010, 5'd22));
        step();
        chk("pre_flush_count", dut.u_queue.count, 3);
        head       = mk(BRU_BEQ, 32'h600c, 32'h1, 32'h1, 32'h8, 1'b1, 32'h6014, 5'd23);
        head_valid = 1'b1;
        commit     = '{enable: 1'b1, flush: 1'b1};
        #1;
        chk("flush_flag", wb_flush, 1);
        chk("flush_we", wb_we, 0);
        chk("flush_pop", pop, 0);
        step();
        commit     = '0;
        head_valid = 1'b0;
        #1;
        chk("post_flush_we", wb_we, 0);
        chk("post_flush_count", dut.u_queue.count, 0);
        chk("post_flush_flag", wb_flush, 0);

        // Reset in the middle of traffic discards in-flight entries.
        issue(mk(BRU_BNE, 32'h7000, 32'h1, 32'h2, 32'h8, 1'b0, 32'h0, 5'd24));
        rst = 1'b0;
        #1;
        chk("midrst_flush", wb_flush, 1);
        chk("midrst_bp_valid", bp_valid, 0);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_we", wb_we, 0);
        chk("midrst_count", dut.u_queue.count, 0);

`ifdef BRU_MISPRED_CNT_EN
        // Two mispredictions and one hit; a flush must not clear the count.
        wb_ready = 1'b1;
        chk("cnt_start", mispred_count, 0);
        issue(mk(BRU_BEQ, 32'h8000, 32'h3, 32'h3, 32'h10, 1'b0, 32'h0, 5'd25));
        step();
        issue(mk(BRU_BNE, 32'h8004, 32'h3, 32'h3, 32'h10, 1'b1, 32'h8014, 5'd26));
        step();
        issue(mk(BRU_BLT, 32'h8008, 32'hFFFF_FFFE, 32'h0, 32'h10, 1'b1, 32'h8018, 5'd27));
        step();
        chk("cnt_after3", mispred_count, 2);
        commit = '{enable: 1'b1, flush: 1'b1};
        step();
        commit = '0;
        #1;
        chk("cnt_after_flush", mispred_count, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_bru_pipe.md
EXECUTE_BRU_PIPE -- requirements
Module: execute_bru_pipe

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- QUEUE_DEPTH, 4: writeback queue entries; power of two, >=2.
- CNT_WIDTH, 32: mispredict counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous, active-low.
- issue_bru_fifo_data_out, in, issue_execute_pack_t: head of the issue FIFO.
- issue_bru_fifo_data_out_valid, in, 1: head valid.
- issue_bru_fifo_pop, out, 1: consume head.
- csrf_all_mepc_data, in, REG_DATA_WIDTH: mepc.
- exbru_cpbuf_id, out, CHECKPOINT_ID_WIDTH: checkpoint read id.
- cpbuf_exbru_data, in, checkpoint_t: checkpoint read data, same cycle.
- bru_wb_port_data_in, out, execute_wb_pack_t: queue head.
- bru_wb_port_we, out, 1: head valid.
- bru_wb_port_ready, in, 1: writeback accepts head.
- bru_wb_port_flush, out, 1: flush writeback port.
- bru_execute_channel_feedback_pack, out, execute_feedback_channel_t: early wakeup.
- commit_feedback_pack, in, commit_feedback_pack_t: commit status and flush.
- exbru_bp_valid/pc/instruction/jump/next_pc/hit/cp, out, 1/ADDR/INSTR/1/ADDR/1/checkpoint_t: predictor update.

Function
REQ-003 Stages SHALL be E1 (one resolve register) followed by a QUEUE_DEPTH-entry FIFO to writeback.
REQ-004 pop SHALL equal valid && !flush_now && (queue_count + e1_valid < QUEUE_DEPTH).
- flush_now = commit_feedback_pack.enable && commit_feedback_pack.flush.
REQ-005 Timing: a pop at edge k loads E1 at k and pushes to the queue at k+1; we SHALL be visible after k+1, giving a minimum latency of 2 cycles.
REQ-006 Resolve at E1 load:
- beq/bne/blt/bge SHALL compare signed; bltu/bgeu SHALL compare unsigned.
- jal SHALL target pc+imm; jalr SHALL target (src1+imm)&~1; mret SHALL target mepc.
- Not taken SHALL give next_pc = pc+4.
- rd_value SHALL be pc+4 for jal/jalr, else 0.
- All sums SHALL wrap at ADDR_WIDTH.
REQ-007 Entries with enable && !valid, or with has_exception, SHALL pass through with bru_jump=0 and the exception fields copied, and SHALL raise no feedback and no bp update.
REQ-008 While E1 holds a valid, non-exception entry:
- Feedback SHALL be asserted the cycle after load when rd_enable && need_rename, with phy_id = rd_phy and value = rd_value.
- exbru_bp_valid SHALL be asserted for exactly 1 cycle.
REQ-009 hit SHALL equal (jump == predicted_jump) && (!jump || predicted_next_pc == next_pc).
REQ-010 exbru_cpbuf_id SHALL equal the issue head checkpoint_id combinationally; exbru_bp_cp SHALL be cpbuf_exbru_data registered at E1 load.
REQ-011 Queue handshake: the head is removed when we && ready. Push and pop in the same cycle SHALL keep the count unchanged; a push when full SHALL never occur (guaranteed by REQ-004).
REQ-012 Pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-013 Flush (flush_now) SHALL, at the edge:
- clear E1 and the queue;
- suppress pop, we, feedback and bp_valid in that cycle;
- assert bru_wb_port_flush in that cycle.

Reset
REQ-014 While rst=0, every output SHALL be 0 except bru_wb_port_flush=1; E1 and the queue SHALL be empty. Reset mid-operation SHALL discard all in-flight entries.

Configuration
REQ-015 With BRU_MISPRED_CNT_EN defined:
- the output mispred_count [CNT_WIDTH] SHALL exist;
- it increments on each bp update with hit=0 and wraps;
- reset clears it; flush does not.
Without the macro, the port and its logic SHALL be absent.

Structure
REQ-016 bru_op_t, the packs and checkpoint_t SHALL stay in the shared common package.
REQ-017 The queue SHALL be the sub-module execute_bru_pipe_queue, parametrised by DEPTH and the entry type.

Verification
REQ-018 The bench SHALL cover these scenarios:
- rst=0 for 2 cycles: flush=1, we=0, pop=0.
- beq with src1=src2=0x15286679, pc=0x1526c2d8, imm=0x18745658, predicted_jump=0: 2 cycles later we=1, next_pc=0x2d9b1930, jump=1, hit=0.
- jal with rd_phy=10, need_rename=1, pc=0x1526c2d8: feedback enable=1, phy_id=10, value=0x1526c2dc one cycle after pop.
- ready=0 with continuous valid issue: exactly QUEUE_DEPTH pops then pop=0. Raising ready drains the entries in order.
- Flush with 3 entries queued: next cycle we=0, count=0, flush=1.
- Macro on: 2 mispredicted branches and 1 correctly predicted branch give mispred_count=2.
